jtframe_lfbuf_line: RTL and testbench



---
 rtl/jtframe_lfbuf_pkg.sv | 22 ++
 rtl/jtframe_lfbuf_dpram.sv | 41 ++++
 rtl/jtframe_lfbuf_line.sv | 181 ++++++++++++++++++
 tb/tb_jtframe_lfbuf_line.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_lfbuf_pkg.sv
// jtframe_lfbuf_pkg: shared definitions for the line-frame buffer front end.
// Holds the line sequencer state encoding and the transparent-pixel nibble mask.
// Imported by jtframe_lfbuf_line; no ports.
package jtframe_lfbuf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_START = 3'd2,
    ST_DRAW  = 3'd3,
    ST_HAND  = 3'd4,
    ST_STOP  = 3'd5
  } lfbuf_st_t;

  // Low nibble of a pixel word; all zeros means "no pixel here"
  localparam logic [3:0] TRANSP_MASK = 4'hF;

  function automatic logic is_transp(input logic [3:0] i_nib);
    return (i_nib & TRANSP_MASK) == 4'h0;
  endfunction

endpackage

// File: rtl/jtframe_lfbuf_dpram.sv
// jtframe_lfbuf_dpram: generic true dual-port RAM, synchronous read on both ports.
// Ports: clk/rst (rst only clears the read registers), per port: i_cen_x gates the
//   read register, i_addr_x, i_din_x, i_we_x (write, independent of cen), o_q_x.
module jtframe_lfbuf_dpram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_cen_a,
  input  logic [AW-1:0] i_addr_a,
  input  logic [DW-1:0] i_din_a,
  input  logic          i_we_a,
  output logic [DW-1:0] o_q_a,
  input  logic          i_cen_b,
  input  logic [AW-1:0] i_addr_b,
  input  logic [DW-1:0] i_din_b,
  input  logic          i_we_b,
  output logic [DW-1:0] o_q_b
);

  logic [DW-1:0] r_mem [0:(2**AW)-1];

  // Both write ports in one process; a same-address collision lets port B win.
  always_ff @(posedge clk) begin
    if (i_we_a) r_mem[i_addr_a] <= i_din_a;
    if (i_we_b) r_mem[i_addr_b] <= i_din_b;
  end

  // Read-before-write: a read at a written address returns the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q_a <= '0;
      o_q_b <= '0;
    end else begin
      if (i_cen_a) o_q_a <= r_mem[i_addr_a];
      if (i_cen_b) o_q_b <= r_mem[i_addr_b];
    end
  end

endmodule

// File: rtl/jtframe_lfbuf_line.sv
// jtframe_lfbuf_line: ping-pong draw line buffer handed to the PSRAM controller,
//   plus the screen-side line pair read out by hdump. Optional macro:
//   JTFRAME_LFBUF_TRANSP_EN drops game writes whose low nibble is zero.
// Ports: game side (ln_addr/ln_data/ln_we/game_done, ln_hs/ln_v), controller side
//   (ln_done, fb_addr/fb_din/fb_clr, rd_addr/fb_dout/scr_we), video (lvbl/lhbl/hdump/ln_pxl).
module jtframe_lfbuf_line
  import jtframe_lfbuf_pkg::*;
#(
  parameter int DW = 16,
  parameter int VW = 8,
  parameter int HW = 9
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          pxl_cen,
  input  logic          lvbl,
  input  logic          lhbl,
  input  logic [HW-1:0] hdump,
  input  logic [HW-1:0] ln_addr,
  input  logic [DW-1:0] ln_data,
  input  logic          ln_we,
  input  logic          game_done,
  output logic          ln_hs,
  output logic [VW-1:0] ln_v,
  output logic          ln_done,
  output logic          frame,
  input  logic [HW-1:0] fb_addr,
  output logic [DW-1:0] fb_din,
  input  logic          fb_clr,
  input  logic [HW-1:0] rd_addr,
  input  logic [DW-1:0] fb_dout,
  input  logic          scr_we,
  output logic [DW-1:0] ln_pxl
);

`ifdef JTFRAME_LFBUF_TRANSP_EN
  localparam logic TRANSP_EN = 1'b1;
`else
  localparam logic TRANSP_EN = 1'b0;
`endif

  lfbuf_st_t     r_st;
  logic          r_wsel;
  logic          r_scr_sel;
  logic          r_busy;
  logic [HW-1:0] r_clr_cnt;
  logic          r_lvbl_l;
  logic          r_lhbl_l;
  logic          r_gd_l;
  logic          r_fbclr_l;

  logic          w_vs;
  logic          w_hb_fall;
  logic          w_gd_rise;
  logic          w_clr_fall;
  logic          w_drop;
  logic [HW-1:0] w_a_addr;
  logic [DW-1:0] w_a_din;
  logic          w_a_we;
  logic [DW-1:0] w_unused_draw_q;
  logic [DW-1:0] w_unused_scr_q;

  // Blanking edges are judged on the pixel clock; controller/game strobes on clk.
  assign w_vs       = pxl_cen & r_lvbl_l & ~lvbl;
  assign w_hb_fall  = pxl_cen & r_lhbl_l & ~lhbl;
  assign w_gd_rise  = game_done & ~r_gd_l;
  assign w_clr_fall = r_fbclr_l & ~fb_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lvbl_l  <= 1'b0;
      r_lhbl_l  <= 1'b0;
      r_gd_l    <= 1'b0;
      r_fbclr_l <= 1'b0;
      r_scr_sel <= 1'b0;
    end else begin
      if (pxl_cen) begin
        r_lvbl_l <= lvbl;
        r_lhbl_l <= lhbl;
      end
      r_gd_l    <= game_done;
      r_fbclr_l <= fb_clr;
      if (w_hb_fall) r_scr_sel <= ~r_scr_sel;
    end
  end

  // Line sequencer. Frame start overrides every state; busy belongs to the
  // controller handshake and is deliberately left alone by an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st      <= ST_IDLE;
      ln_hs     <= 1'b0;
      ln_done   <= 1'b0;
      ln_v      <= '0;
      frame     <= 1'b0;
      r_wsel    <= 1'b0;
      r_busy    <= 1'b0;
      r_clr_cnt <= '0;
    end else begin
      ln_hs   <= 1'b0;
      ln_done <= 1'b0;
      if (w_clr_fall) r_busy <= 1'b0;
      if (w_vs) begin
        frame     <= ~frame;
        ln_v      <= '0;
        r_clr_cnt <= '0;
        r_st      <= ST_CLR;
      end else begin
        case (r_st)
          ST_IDLE: ;
          ST_CLR: begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            if (&r_clr_cnt) r_st <= ST_START;
          end
          ST_START: begin
            if (!r_busy) begin
              ln_hs <= 1'b1;
              r_st  <= ST_DRAW;
            end
          end
          ST_DRAW: begin
            if (w_gd_rise) r_st <= ST_HAND;
          end
          ST_HAND: begin
            if (!r_busy) begin
              r_wsel  <= ~r_wsel;
              ln_done <= 1'b1;
              r_busy  <= 1'b1;
              if (&ln_v) begin
                r_st <= ST_STOP;
              end else begin
                ln_v <= ln_v + 1'b1;
                r_st <= ST_START;
              end
            end
          end
          ST_STOP: ;
          default: r_st <= ST_IDLE;
        endcase
      end
    end
  end

  // Port A belongs to the sequencer during CLR and to the game during DRAW.
  assign w_drop   = TRANSP_EN & is_transp(ln_data[3:0]);
  assign w_a_addr = (r_st == ST_CLR) ? r_clr_cnt : ln_addr;
  assign w_a_din  = (r_st == ST_CLR) ? '0 : ln_data;
  assign w_a_we   = (r_st == ST_CLR) | ((r_st == ST_DRAW) & ln_we & ~w_drop);

  jtframe_lfbuf_dpram #(.AW(HW+1), .DW(DW)) u_draw (
    .clk      (clk),
    .rst      (rst),
    .i_cen_a  (1'b1),
    .i_addr_a ({r_wsel, w_a_addr}),
    .i_din_a  (w_a_din),
    .i_we_a   (w_a_we),
    .o_q_a    (w_unused_draw_q),
    .i_cen_b  (1'b1),
    .i_addr_b ({~r_wsel, fb_addr}),
    .i_din_b  ({DW{1'b0}}),
    .i_we_b   (fb_clr),
    .o_q_b    (fb_din)
  );

  // Screen pair: controller fills half scr_sel while the other half is shown.
  jtframe_lfbuf_dpram #(.AW(HW+1), .DW(DW)) u_scr (
    .clk      (clk),
    .rst      (rst),
    .i_cen_a  (1'b1),
    .i_addr_a ({r_scr_sel, rd_addr}),
    .i_din_a  (fb_dout),
    .i_we_a   (scr_we),
    .o_q_a    (w_unused_scr_q),
    .i_cen_b  (pxl_cen),
    .i_addr_b ({~r_scr_sel, hdump}),
    .i_din_b  ({DW{1'b0}}),
    .i_we_b   (1'b0),
    .o_q_b    (ln_pxl)
  );

endmodule

// File: tb/tb_jtframe_lfbuf_line.sv
// tb_jtframe_lfbuf_line: self-checking bench for jtframe_lfbuf_line.
// Table of game writes with a small memory model, a read scoreboard for fb_din,
// and hand-written sequences for handshake, screen buffer, abort and STOP.
module tb_jtframe_lfbuf_line;

  localparam int DW = 16;
  localparam int VW = 8;
  localparam int HW = 9;
`ifdef JTFRAME_LFBUF_TRANSP_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic          rst, clk, pxl_cen, lvbl, lhbl;
  logic [HW-1:0] hdump, ln_addr, fb_addr, rd_addr;
  logic [DW-1:0] ln_data, fb_dout, fb_din, ln_pxl;
  logic          ln_we, game_done, ln_hs, ln_done, frame, fb_clr, scr_we;
  logic [VW-1:0] ln_v;

  jtframe_lfbuf_line #(.DW(DW), .VW(VW), .HW(HW)) dut (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .lvbl(lvbl), .lhbl(lhbl),
    .hdump(hdump), .ln_addr(ln_addr), .ln_data(ln_data), .ln_we(ln_we),
    .game_done(game_done), .ln_hs(ln_hs), .ln_v(ln_v), .ln_done(ln_done),
    .frame(frame), .fb_addr(fb_addr), .fb_din(fb_din), .fb_clr(fb_clr),
    .rd_addr(rd_addr), .fb_dout(fb_dout), .scr_we(scr_we), .ln_pxl(ln_pxl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial pxl_cen = 1'b0;
  always @(posedge clk) begin
    #1 pxl_cen = ~pxl_cen;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [HW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           tbl [0:5];
  logic [DW-1:0] mdl [0:(2**HW)-1];
  int            rd_list [0:6];
  logic [DW-1:0] sb_q [$];

  int checks = 0, errors = 0;
  int cyc = 0, hs_cnt = 0, done_cnt = 0, hs_cyc = 0, done_cyc = 0, frame_cyc = 0;
  int exp_hs = 0, exp_done = 0, g_cyc = 0, f_cyc = 0;
  logic [VW-1:0] hs_v = '0;
  logic          last_frame = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clk; outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (ln_hs) begin hs_cnt++; hs_cyc = cyc; hs_v = ln_v; end
    if (ln_done) begin done_cnt++; done_cyc = cyc; end
    if (frame !== last_frame) begin frame_cyc = cyc; last_frame = frame; end
  endtask

  task automatic wait_hs(input int target);
    for (int i = 0; i < 2000 && hs_cnt < target; i++) step();
    chk("ln_hs_seen", 32'(hs_cnt >= target), 32'd1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 200 && done_cnt < target; i++) step();
    chk("ln_done_seen", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic fb_rd(input logic [HW-1:0] a, input logic [DW-1:0] exp);
    fb_addr = a;
    sb_q.push_back(exp);
    step();
    chk($sformatf("fb_din@%0d", a), 32'(fb_din), 32'(sb_q.pop_front()));
  endtask

  task automatic pulse_gd();
    game_done = 1'b1; g_cyc = cyc; step();
    game_done = 1'b0;
  endtask

  task automatic pulse_clr();
    fb_clr = 1'b1; step(); step();
    fb_clr = 1'b0; step();
  endtask

  task automatic do_line(input int line);
    exp_hs++;
    wait_hs(exp_hs);
    chk("ln_v_at_hs", 32'(hs_v), 32'(line));
    pulse_gd();
    exp_done++;
    wait_done(exp_done);
    pulse_clr();
  endtask

  initial begin
    tbl[0] = '{addr: 9'd5,  data: 16'h1234};
    tbl[1] = '{addr: 9'd7,  data: 16'h7777};
    tbl[2] = '{addr: 9'd7,  data: 16'h5550};
    tbl[3] = '{addr: 9'd9,  data: 16'h00A0};
    tbl[4] = '{addr: 9'd12, data: 16'h0F0F};
    tbl[5] = '{addr: 9'd12, data: 16'h8881};
    rd_list = '{0, 5, 7, 9, 12, 3, 511};
    for (int i = 0; i < 2**HW; i++) mdl[i] = '0;
    for (int i = 0; i < 6; i++)
      if (!(TRANSP && tbl[i].data[3:0] == 4'h0)) mdl[tbl[i].addr] = tbl[i].data;

    rst = 1'b1; lvbl = 1'b1; lhbl = 1'b1; hdump = '0; ln_addr = '0; ln_data = '0;
    ln_we = 1'b0; game_done = 1'b0; fb_addr = '0; fb_clr = 1'b0; rd_addr = '0;
    fb_dout = '0; scr_we = 1'b0;
    repeat (4) step();
    chk("rst_ln_hs", 32'(ln_hs), 0);
    chk("rst_ln_done", 32'(ln_done), 0);
    chk("rst_ln_v", 32'(ln_v), 0);
    chk("rst_frame", 32'(frame), 0);
    chk("rst_fb_din", 32'(fb_din), 0);
    chk("rst_ln_pxl", 32'(ln_pxl), 0);
    rst = 1'b0;
    repeat (4) step();

    // Screen buffer: fill half 0, flip on lhbl fall, read it back via hdump
    rd_addr = 9'd10; fb_dout = 16'hABCD; scr_we = 1'b1; step();
    scr_we = 1'b0; hdump = 9'd10; lhbl = 1'b0;
    for (int i = 0; i < 12 && ln_pxl !== 16'hABCD; i++) step();
    chk("ln_pxl_half0", 32'(ln_pxl), 32'hABCD);
    fb_dout = 16'h1111; scr_we = 1'b1; step();
    scr_we = 1'b0;
    repeat (6) step();
    chk("ln_pxl_hold", 32'(ln_pxl), 32'hABCD);
    lhbl = 1'b1; repeat (4) step();
    lhbl = 1'b0;
    for (int i = 0; i < 12 && ln_pxl !== 16'h1111; i++) step();
    chk("ln_pxl_half1", 32'(ln_pxl), 32'h1111);

    // First frame: CLR sweep then line 0 start
    lvbl = 1'b0;
    exp_hs = 1;
    wait_hs(1);
    chk("clr_len", 32'(hs_cyc - frame_cyc), 32'd513);
    chk("frame_1", 32'(frame), 1);
    chk("hs_v0", 32'(hs_v), 0);

    for (int i = 0; i < 6; i++) begin
      ln_addr = tbl[i].addr; ln_data = tbl[i].data; ln_we = 1'b1; step();
    end
    ln_we = 1'b0;
    pulse_gd();
    exp_done = 1;
    wait_done(1);
    chk("ln_done_lat", 32'(done_cyc - g_cyc), 32'd2);
    chk("ln_v_1", 32'(ln_v), 1);
    step();
    chk("ln_done_1clk", 32'(ln_done), 0);
    for (int i = 0; i < 7; i++) fb_rd(9'(rd_list[i]), mdl[rd_list[i]]);

    // Controller clears half 0 while a stray game_done arrives outside DRAW
    fb_clr = 1'b1;
    for (int i = 0; i < 7; i++) begin
      fb_addr = 9'(rd_list[i]); step();
      if (i == 2) game_done = 1'b1;
      if (i == 3) game_done = 1'b0;
    end
    chk("no_hs_busy", 32'(hs_cnt), 1);
    chk("no_done_busy", 32'(done_cnt), 1);
    chk("ln_v_hold", 32'(ln_v), 1);
    fb_clr = 1'b0; f_cyc = cyc;
    exp_hs = 2;
    wait_hs(2);
    chk("hs_after_clr", 32'(hs_cyc - f_cyc), 32'd2);
    chk("gd_ignored", 32'(done_cnt), 1);
    chk("ln_v_still1", 32'(ln_v), 1);
    pulse_gd();
    exp_done = 2;
    wait_done(2);
    chk("ln_v_2", 32'(ln_v), 2);

    // Write outside DRAW (START while busy) must not land in half 0
    ln_addr = 9'd3; ln_data = 16'hBEEF; ln_we = 1'b1; step();
    ln_we = 1'b0;
    pulse_clr();
    do_line(2);
    fb_rd(9'd3, 16'h0000);
    fb_rd(9'd5, 16'h0000);
    for (int l = 3; l <= 36; l++) do_line(l);

    // Abort line 37 mid-draw with a new frame
    exp_hs++;
    wait_hs(exp_hs);
    chk("hs_v37", 32'(hs_v), 37);
    ln_addr = 9'd20; ln_data = 16'h1357; ln_we = 1'b1; step();
    ln_addr = 9'd5;  ln_data = 16'h2468; step();
    ln_we = 1'b0;
    lvbl = 1'b1; repeat (4) step();
    lvbl = 1'b0;
    for (int i = 0; i < 10 && frame !== 1'b0; i++) step();
    chk("frame_toggle", 32'(frame), 0);
    chk("ln_v_abort", 32'(ln_v), 0);
    exp_hs++;
    wait_hs(exp_hs);
    chk("clr_len2", 32'(hs_cyc - frame_cyc), 32'd513);
    chk("hs_v0_again", 32'(hs_v), 0);
    pulse_gd();
    exp_done++;
    wait_done(exp_done);
    fb_rd(9'd20, 16'h0000);
    fb_rd(9'd5, 16'h0000);
    fb_rd(9'd511, 16'h0000);
    pulse_clr();

    for (int l = 1; l <= 254; l++) do_line(l);
    exp_hs++;
    wait_hs(exp_hs);
    chk("hs_v255", 32'(hs_v), 255);
    pulse_gd();
    exp_done++;
    wait_done(exp_done);
    chk("ln_v_stop", 32'(ln_v), 255);
    pulse_clr();
    repeat (20) step();
    chk("stop_no_hs", 32'(hs_cnt), 32'(exp_hs));
    chk("stop_ln_v", 32'(ln_v), 255);
    chk("done_total", 32'(done_cnt), 32'(exp_done));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
